// File: rtl/sha256_round_reader.sv
//==============================================================================
// Module      : sha256_round_reader
// Description : Iterative SHA-256 compression over W_t words streamed from the
//               W-memory window; one round per cycle, then chaining-value add.
// Options     : SHA256_ROUND_STALL_EN adds w_valid to stall rounds.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sha256_round_reader #(
  parameter int ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic [31:0]  w_in,
`ifdef SHA256_ROUND_STALL_EN
  input  logic         w_valid,
`endif
  output logic         w_adv,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ROUND   = 2'd1;
  localparam logic [1:0] ST_FINAL   = 2'd2;
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  logic [1:0]   r_state;
  logic [1:0]   w_next_state;
  logic [5:0]   r_round;
  logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [255:0] r_hv;
  logic [255:0] r_digest;
  logic [31:0]  w_t1, w_t2;
  logic [255:0] w_sum;
  logic         w_wv;

`ifdef SHA256_ROUND_STALL_EN
  assign w_wv = w_valid;
`else
  assign w_wv = 1'b1;
`endif

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  default: k = 32'hc67178f2;
    endcase
    return k;
  endfunction

  assign w_t1 = r_h + big_sigma1(r_e) + ((r_e & r_f) ^ (~r_e & r_g)) + k_rom(r_round) + w_in;
  assign w_t2 = big_sigma0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));

  assign w_sum = {r_hv[255:224] + r_a, r_hv[223:192] + r_b,
                  r_hv[191:160] + r_c, r_hv[159:128] + r_d,
                  r_hv[127:96]  + r_e, r_hv[95:64]   + r_f,
                  r_hv[63:32]   + r_g, r_hv[31:0]    + r_h};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_ROUND;
      ST_ROUND: if (w_wv && (r_round == LAST_ROUND)) w_next_state = ST_FINAL;
      ST_FINAL: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Digest is driven straight from the adder during FINAL so it is valid with done.
  always_comb begin
    w_adv  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    digest = r_digest;
    case (r_state)
      ST_ROUND: begin
        w_adv = w_wv;
        busy  = 1'b1;
      end
      ST_FINAL: begin
        busy   = 1'b1;
        done   = 1'b1;
        digest = w_sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_round  <= 6'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_c      <= 32'd0;
      r_d      <= 32'd0;
      r_e      <= 32'd0;
      r_f      <= 32'd0;
      r_g      <= 32'd0;
      r_h      <= 32'd0;
      r_hv     <= 256'd0;
      r_digest <= 256'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_hv    <= h_in;
            r_round <= 6'd0;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= h_in;
          end
        end
        ST_ROUND: begin
          if (w_wv) begin
            r_a     <= w_t1 + w_t2;
            r_b     <= r_a;
            r_c     <= r_b;
            r_d     <= r_c;
            r_e     <= r_d + w_t1;
            r_f     <= r_e;
            r_g     <= r_f;
            r_h     <= r_g;
            r_round <= r_round + 6'd1;
          end
        end
        ST_FINAL: r_digest <= w_sum;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_round_reader.sv
//==============================================================================
// Module      : tb_sha256_round_reader
// Description : Scoreboard bench for sha256_round_reader with a W-memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sha256_round_reader;

  localparam logic [255:0] IV   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] MSG2 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_M1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2  = {{15{32'h0}}, 32'h000001c0};

  logic         CLK, RST, start;
  logic [255:0] h_in;
  logic [31:0]  w_in;
  logic         w_adv, busy, done;
  logic [255:0] digest;
`ifdef SHA256_ROUND_STALL_EN
  logic         w_valid;
`endif

  sha256_round_reader #(.ROUNDS(64)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .h_in   (h_in),
    .w_in   (w_in),
`ifdef SHA256_ROUND_STALL_EN
    .w_valid(w_valid),
`endif
    .w_adv  (w_adv),
    .busy   (busy),
    .done   (done),
    .digest (digest)
  );

  typedef struct {
    logic [255:0] dig;
    int           start_cyc;
    int           lat;
    bit           chk;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_push   = 0;
  int          n_done   = 0;
  int          cyc      = 0;
  int          adv_cnt  = 0;
  logic [31:0] sched [64];
  logic [5:0]  ptr;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  // W-memory window model: presents sched[ptr], advances on w_adv
  assign w_in = sched[ptr];
  always @(posedge CLK or negedge RST) begin
    if (!RST) ptr <= 6'd0;
    else if (w_adv) ptr <= ptr + 6'd1;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic load_sched(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) sched[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      sched[t] = (rotr(sched[t-2], 17) ^ rotr(sched[t-2], 19) ^ (sched[t-2] >> 10)) + sched[t-7] +
                 (rotr(sched[t-15], 7) ^ rotr(sched[t-15], 18) ^ (sched[t-15] >> 3)) + sched[t-16];
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic issue_start(input logic [255:0] h, input logic [255:0] exp_dig,
                             input bit chk, input bit push, input int lat);
    exp_t e;
    h_in  = h;
    start = 1'b1;
    if (push) begin
      e.dig = exp_dig; e.start_cyc = cyc; e.lat = lat; e.chk = chk;
      sb.push_back(e);
      n_push++;
    end
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_timeout: got no done within 300 cycles, expected one");
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      adv_cnt = 0;
    end else if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        if (e.chk) check("digest", digest, e.dig);
        check("latency", 256'(cyc - e.start_cyc), 256'(e.lat));
        check("w_adv_count", 256'(adv_cnt), 256'd64);
        check("busy_at_done", {255'd0, busy}, 256'd1);
        check("w_adv_in_final", {255'd0, w_adv}, 256'd0);
      end
      adv_cnt = 0;
    end else if (w_adv) begin
      adv_cnt++;
    end
  end

  initial begin
    RST   = 1'b0;
    start = 1'b0;
    h_in  = 256'd0;
`ifdef SHA256_ROUND_STALL_EN
    w_valid = 1'b1;
`endif
    load_sched(BLK_ABC);
    repeat (3) @(posedge CLK);
    #1;
    check("reset_busy",   {255'd0, busy},  256'd0);
    check("reset_done",   {255'd0, done},  256'd0);
    check("reset_w_adv",  {255'd0, w_adv}, 256'd0);
    check("reset_digest", digest,          256'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Case 1: "abc" single block
    issue_start(IV, ABC, 1'b1, 1'b1, 65);
    wait_done();
    repeat (4) @(posedge CLK);
    #1;
    check("digest_hold", digest, ABC);

    // Case 2: starts during round 10 and during FINAL are ignored
    issue_start(IV, ABC, 1'b1, 1'b1, 65);
    repeat (10) @(posedge CLK);
    #1;
    start = 1'b1;
    h_in  = {8{32'hdeadbeef}};
    check("digest_kept_on_start", digest, ABC);
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done();
    start = 1'b1;
    h_in  = {8{32'h55555555}};
    @(posedge CLK); #1;
    start = 1'b0;

    // Case 3: two-block message, second block started the cycle after done
    load_sched(BLK_M1);
    issue_start(IV, 256'd0, 1'b0, 1'b1, 65);
    wait_done();
    @(posedge CLK); #1;
    load_sched(BLK_M2);
    issue_start(digest, MSG2, 1'b1, 1'b1, 65);
    wait_done();
    @(posedge CLK); #1;

    // Case 4: reset at round 30 aborts the block
    load_sched(BLK_ABC);
    issue_start(IV, 256'd0, 1'b0, 1'b0, 65);
    repeat (30) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("abort_busy",   {255'd0, busy},  256'd0);
    check("abort_done",   {255'd0, done},  256'd0);
    check("abort_w_adv",  {255'd0, w_adv}, 256'd0);
    check("abort_digest", digest,          256'd0);
    repeat (3) @(posedge CLK);
    #1;
    check("abort_busy_held", {255'd0, busy}, 256'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    issue_start(IV, ABC, 1'b1, 1'b1, 65);
    wait_done();
    @(posedge CLK); #1;

`ifdef SHA256_ROUND_STALL_EN
    // Case 5: three stall cycles on rounds 0, 17 and 63
    issue_start(IV, ABC, 1'b1, 1'b1, 74);
    for (int r = 0; r < 64; r++) begin
      if (r == 0 || r == 17 || r == 63) begin
        w_valid = 1'b0;
        repeat (3) begin
          #1;
          check("stall_no_w_adv", {255'd0, w_adv}, 256'd0);
          @(posedge CLK); #1;
        end
        w_valid = 1'b1;
      end
      @(posedge CLK); #1;
    end
    wait_done();
    @(posedge CLK); #1;
`endif

    repeat (5) @(posedge CLK);
    #1;
    check("scoreboard_drained", 256'(sb.size()), 256'd0);
    check("done_count", 256'(n_done), 256'(n_push));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sha256_round_reader.md
Name: sha256_round_reader

Overview:
- Iterative SHA-256 compression engine that consumes schedule words W_t produced by the pipelined W-memory window.
- Issues one advance strobe per round to the W-memory (its write_en) and reads the current W_t each round.
- Runs 64 rounds, adds the chaining value, and presents the 256-bit digest.
- Sits downstream of the W-expander pipeline in each hash lane of the double-SHA256 datapath.

Parameters:
- ROUNDS, 64, number of compression rounds; fixed at 64 for SHA-256, kept as a parameter for reduced-round bench builds.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin compression; sampled only in IDLE.
- h_in  input  256  chaining value H0..H7, H0 in [255:224].
- w_in  input  32  current schedule word W_t from the W-memory.
- w_adv  output  1  advance strobe to the W-memory, asserted in each cycle W_t is consumed.
- busy  output  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
- done  output  1  one-cycle pulse; digest valid.
- digest  output  256  H + final working state, H0' in [255:224].

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; round counter=0; a..h=0; H registers=0; digest=0; w_adv=0; busy=0; done=0.
- Clock and reset: the single clock domain is CLK; reset is asynchronous and active-low.
- IDLE, start=1:
  - latch h_in into the H registers and into a..h;
  - round=0; go to ROUND; busy=1 from the next cycle.
- ROUND, each cycle:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[round] + w_in; T2 = Σ0(a) + Maj(a,b,c).
  - All additions are 32-bit modulo 2^32; carries are discarded.
  - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - w_adv=1 combinationally in the same cycle; round increments.
  - When round==ROUNDS-1, go to FINAL.
- K constants: the standard 64-entry SHA-256 table, held as a case ROM indexed by the 6-bit round counter.
- FINAL (one cycle):
  - digest word i = H_i + working word i, mod 2^32;
  - done=1 for exactly this cycle; busy=1 this cycle;
  - go to IDLE next cycle.
- Digest hold: digest holds its value until the next FINAL or reset. It is not cleared on a new start.
- Latency: start accepted at cycle N; rounds occupy cycles N+1..N+64; done at cycle N+65.
- w_adv: exactly 64 pulses per block, never asserted in IDLE or FINAL.
- start while busy (ROUND or FINAL): ignored, with no effect on state or counters.
- start in the cycle after done (IDLE): accepted, giving back-to-back blocks with 1 idle cycle.
- h_in is sampled only at start acceptance; later changes have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs zero; no done pulse is produced for the aborted block.

Optional Feature:
- Macro: SHA256_ROUND_STALL_EN.
- With the macro defined:
  - adds input w_valid (1 bit);
  - in ROUND, the round executes only when w_valid=1;
  - w_adv = w_valid in ROUND;
  - when w_valid=0, the working state, counter and w_adv hold; w_adv=0;
  - latency = 65 + number of stall cycles; exactly 64 w_adv pulses are still guaranteed.
- Without the macro: no w_valid port; W_t is treated as valid every ROUND cycle, as above.

Test Plan:
- Case 1 ("abc"): h_in = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; bench model supplies W_t for the padded "abc" block; pulse start → done at start+65; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; count exactly 64 w_adv pulses.
- Case 2 (start while busy): pulse start again at round 10 and at FINAL → ignored; digest still equals the "abc" value; single done pulse.
- Case 3 (back-to-back): second start one cycle after done, with h_in = first digest and W_t for the 2nd padded block of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Case 4 (reset mid-round): drop RST at round 30 → outputs zero immediately; busy=0; no done. A later start recomputes "abc" correctly.
- Case 5 (stall, SHA256_ROUND_STALL_EN): w_valid low on rounds 0, 17 and 63 for 3 cycles each → done at start+74; same "abc" digest; 64 w_adv pulses; no w_adv while w_valid=0.
